// File: rtl/pe_param_fifo.sv
// Parametrised synchronous FIFO for PE operand/activation queues.
// Arbitrary depth, programmable thresholds, occupancy count, optional FWFT.
module pe_param_fifo #(
    parameter int nb_data = 16,
    parameter int L_data  = 12,
    parameter int FWFT    = 0,
    parameter int AF_TH   = nb_data - 2,
    parameter int AE_TH   = 2,
    parameter int L_addr  = $clog2(nb_data),
    parameter int L_cnt   = $clog2(nb_data + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [L_data-1:0] DataIn,
    input  logic              write,
    input  logic              read,
    input  logic              flush,
    input  logic              err_clr,
    output logic [L_data-1:0] DataOut,
    output logic              rd_valid,
    output logic              stk_full,
    output logic              stk_almost_full,
    output logic              stk_half_full,
    output logic              stk_almost_empty,
    output logic              stk_empty,
    output logic [L_cnt-1:0]  data_count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [L_cnt-1:0]  C_FULL = L_cnt'(nb_data);
    localparam logic [L_cnt-1:0]  C_HALF = L_cnt'(nb_data / 2);
    localparam logic [L_cnt-1:0]  C_AF   = L_cnt'(AF_TH);
    localparam logic [L_cnt-1:0]  C_AE   = L_cnt'(AE_TH);
    localparam logic [L_addr-1:0] C_LAST = L_addr'(nb_data - 1);

    logic [L_data-1:0] r_mem [nb_data];
    logic [L_addr-1:0] r_wr_ptr;
    logic [L_addr-1:0] r_rd_ptr;
    logic [L_cnt-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is still taken when a read frees a slot
    assign w_rd_acc  = read & ~flush & ~w_empty;
    assign w_wr_acc  = write & ~flush & (~w_full | w_rd_acc);
    assign w_ovf_set = write & ~flush & w_full & ~w_rd_acc;
    assign w_unf_set = read & ~flush & w_empty;

    assign stk_full         = w_full;
    assign stk_empty        = w_empty;
    assign stk_half_full    = (r_count >= C_HALF);
    assign stk_almost_full  = (r_count >= C_AF);
    assign stk_almost_empty = (r_count <= C_AE);
    assign data_count       = r_count;
    assign overflow         = r_ovf;
    assign underflow        = r_unf;

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= DataIn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + L_addr'(1);
            if (w_rd_acc)
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + L_addr'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + L_cnt'(1);
                2'b01:   r_count <= r_count - L_cnt'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // New error events take priority over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
            r_unf <= w_unf_set | (r_unf & ~err_clr);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign DataOut  = r_mem[r_rd_ptr];
            assign rd_valid = ~w_empty;
        end else begin : g_std
            logic [L_data-1:0] r_dout;
            logic              r_vld;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= '0;
                    r_vld  <= 1'b0;
                end else begin
                    if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
                    r_vld <= w_rd_acc;
                end
            end
            assign DataOut  = r_dout;
            assign rd_valid = r_vld;
        end
    endgenerate

endmodule

// File: doc/pe_param_fifo.md
# pe_param_fifo

Parametrised synchronous FIFO for PE operand/activation queues: the next-generation queue. Adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, an occupancy count, a first-word-fall-through (FWFT) mode, synchronous flush, and sticky overflow/underflow error flags. Sits between the PE input stream and the PE datapath, replacing fixed-depth queues where per-layer tuning of depth and thresholds is needed.

## Interface
- nb_data, 16, storage depth in words; any integer ≥ 2
- L_data, 12, word width in bits
- FWFT, 0, 0 = standard (registered read data), 1 = first-word-fall-through
- AF_TH, nb_data-2, stk_almost_full asserts when count ≥ AF_TH; range 1..nb_data
- AE_TH, 2, stk_almost_empty asserts when count ≤ AE_TH; range 0..nb_data-1
- L_addr, clogb2(nb_data), pointer width; L_cnt = clogb2(nb_data+1) is the count width
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- DataIn  in  L_data  write data
- write  in  1  write request
- read  in  1  read request
- flush  in  1  synchronous clear of contents
- err_clr  in  1  synchronous clear of overflow/underflow
- DataOut  out  L_data  read data
- rd_valid  out  1  DataOut qualifier
- stk_full, stk_almost_full, stk_half_full, stk_almost_empty, stk_empty  out  1 each  status flags
- data_count  out  L_cnt  current occupancy 0..nb_data
- overflow  out  1  sticky: write requested while full and not accepted
- underflow  out  1  sticky: read requested while empty

## Operation
- Storage: nb_data × L_data register array; write_ptr, read_ptr in 0..nb_data-1, each wraps nb_data-1 → 0 (explicit compare, not bit overflow).
- Accept rules (evaluated on registered count): wr_acc = write & (!full | rd_acc); rd_acc = read & !empty.
  - Full, write+read together: both accepted, count unchanged, oldest word read, new word stored.
  - Empty, write+read together: write accepted, read rejected, underflow set.
- Count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both/neither. Never exceeds nb_data or goes below 0.
- Flags are decoded from registered count: full = (count == nb_data), empty = (count == 0), half_full = (count ≥ nb_data/2, integer divide), almost_full = (count ≥ AF_TH), almost_empty = (count ≤ AE_TH).
- Errors: overflow set when write & full & !rd_acc; underflow set when read & empty. Sticky until err_clr; err_clr in the same cycle as a new error event leaves the flag set (set wins).
- flush: pointers and count → 0, rd_valid → 0; write/read in a flush cycle are dropped with no error. Memory contents and DataOut value not cleared. Error flags unaffected by flush.
- Standard mode (FWFT=0): DataOut registered; loaded with mem[read_ptr] on rd_acc; holds otherwise. rd_valid = 1 for exactly the cycle after each rd_acc.
- FWFT mode (FWFT=1): DataOut = mem[read_ptr] combinationally; rd_valid = !empty; read acts as acknowledge of the presented head word.

## Timing
- Reset (rst_n low, async): pointers, data_count, DataOut, rd_valid, overflow, underflow all 0; stk_empty = 1, stk_almost_empty = 1, all other flags 0.
- Write latency: word written at edge N is counted/flag-visible after edge N; in FWFT it appears on DataOut after edge N (empty → nonempty one cycle after write).
- Standard-mode read latency: 1 cycle (read at edge N, data + rd_valid valid after edge N).
- Back-to-back reads/writes every cycle sustained at full throughput; no bubble at pointer wrap.
- Reset deasserted mid-stream: FIFO restarts empty; no pending read data emitted.

## Test plan
- nb_data=6, FWFT=0: write 0x001..0x006 on 6 consecutive cycles -> count 1..6, stk_full after 6th, stk_almost_full at count 4; 7th write -> not stored, overflow=1; read 6 -> DataOut 0x001..0x006 each with rd_valid one cycle after read, stk_empty after last.
- Wrap: nb_data=6, 20 cycles simultaneous write+read at count 3 -> count constant 3, output sequence in-order across pointer wrap, no flag changes.
- Full+simultaneous: at count 6 assert write(0x0AA)+read -> both accepted, count 6, no overflow; empty+simultaneous -> write accepted, count 1, underflow=1; err_clr -> underflow 0 next cycle.
- FWFT=1: write 0x123 into empty -> next cycle DataOut=0x123, rd_valid=1; read -> next cycle rd_valid=0, stk_empty=1.
- Flush at count 4 with write+read asserted -> next cycle count 0, stk_empty=1, no error flags; then write 0x055, read -> 0x055 returned.
- Async reset asserted mid-burst at count 5 -> immediately count 0, rd_valid 0, overflow/underflow 0, stk_empty 1.
